simple_cpu_top: RTL and testbench
=================================

// Module: simple_cpu_top
// PURPOSE
//  8-bit multicycle accumulator-free register CPU; top of the simple_cpu design.
//  Harvard: 256x16 instruction memory via im_* bus, 256x8 data memory via dm_* bus.
//  Memories are external and are read with one cycle of latency.
// PARAMETERS
//  none (widths fixed: data 8, instr 16, addresses 8)
// PORTS
//  clk            in   1   rising-edge clock, single clock domain
//  reset          in   1   asynchronous, active-high
//  im_abus_valid  out  1   instruction address valid (fetch in progress)
//  im_abus_data   out  8   instruction address (= PC)
//  im_dbus        in   16  instruction word from instruction memory
//  rd_mem         out  1   data memory read strobe
//  wr_mem         out  1   data memory write strobe (memory writes on posedge while high)
//  dm_abus        out  8   data memory address
//  dm_in_dbus     in   8   read data from data memory
//  dm_out_dbus    out  8   write data to data memory
// BEHAVIOUR
//  Reset: PC=0, r0..r7=0, Z=C=0, IR=0, state=F1; all outputs 0.
//  Encoding: op[15:12] rd[11:9] ra[8:6] rb[5:3]; imm8=[7:0]. Unused bits ignored.
//  0 NOP | 1 ADD rd=ra+rb | 2 SUB rd=ra-rb | 3 AND | 4 OR | 5 XOR
//  6 SHL rd=ra<<1 (C=ra[7]) | 7 SHR rd=ra>>1 (C=ra[0]) | 8 LDI rd=imm8
//  9 LD rd=mem[imm8] | A ST mem[imm8]=rd | B JMP PC=imm8
//  C BZ if Z PC=imm8 | D BNZ if !Z PC=imm8 | E ADDI rd=rd+imm8 | F HALT
//  Flags: ops 1-7,E update Z (result==0) and C (ADD/ADDI carry-out, SUB borrow,
//   AND/OR/XOR C=0). LDI/LD/ST/branches leave flags unchanged.
//  Arithmetic modulo 256; PC wraps 0xFF->0x00; non-taken branch PC=PC+1.
//  FSM: F1 -> F2 -> EX -> {F1 | M1 | HALT}.
//   F1: im_abus_valid=1, im_abus_data=PC.
//   F2: same outputs held; IR<=im_dbus at end of F2.
//   EX: decode/ALU; write rd, flags, PC. LD/ST go to M1 (PC already +1).
//   M1: dm_abus=imm8. LD: rd_mem=1. ST: wr_mem=1, dm_out_dbus=rd; -> F1.
//   M2 (LD only): rd_mem=1, dm_abus held; rd<=dm_in_dbus at end of M2; -> F1.
//   HALT: terminal; only reset exits. Outputs 0.
//  CPI: ALU/branch/NOP 3, ST 4, LD 5.
//  im_abus_valid=0 and im_abus_data holds PC outside F1/F2.
//  rd_mem/wr_mem never both high; dm_abus, dm_out_dbus =0 outside M1/M2.
//  Reset mid-instruction aborts it immediately; no partial register/memory write.
//  ST of rd after write to rd in previous instruction sees the new value.
// STRUCTURE
//  Package simple_cpu_pkg: opcode localparams, FSM state encoding, field slices.
//  Sub-module simple_cpu_alu: comb, inputs a,b[7:0], op[3:0]; outputs y[7:0], z, c.
//  Top: PC, IR, 8x8 register file, flags, FSM, bus drivers.
// TESTING
//  1 Reset held 100 ns -> im_abus_valid=0, rd_mem=wr_mem=0; first fetch addr 0x00.
//  2 LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2; ST r3,[0x10] -> mem[0x10]=0x08,
//    wr_mem pulse exactly 1 cycle with dm_abus=0x10.
//  3 mem[0x20]=0xAA; LD r4,[0x20]; ST r4,[0x21] -> mem[0x21]=0xAA; rd_mem high 2 cycles.
//  4 LDI r1,0xFF; ADDI r1,0x01 -> r1=0x00, Z=1, C=1; BZ 0x40 -> next fetch addr 0x40.
//  5 Countdown loop r1=3, SUB r1,r1,r2 (r2=1), BNZ back -> 3 iterations, then falls through.
//  6 HALT -> no further fetches; JMP 0xFF then NOP at 0xFF -> next fetch addr 0x00.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared opcodes, FSM states and instruction field helpers for the simple_cpu design.
package simple_cpu_pkg;

   localparam int unsigned DW   = 8;
   localparam int unsigned IW   = 16;
   localparam int unsigned AW   = 8;
   localparam int unsigned NREG = 8;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_BZ   = 4'hC;
   localparam logic [3:0] OP_BNZ  = 4'hD;
   localparam logic [3:0] OP_ADDI = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {S_F1, S_F2, S_EX, S_M1, S_M2, S_HALT} state_t;

   function automatic logic [3:0] f_op(input logic [IW-1:0] ir);
      return ir[15:12];
   endfunction

   function automatic logic [2:0] f_rd(input logic [IW-1:0] ir);
      return ir[11:9];
   endfunction

   function automatic logic [2:0] f_ra(input logic [IW-1:0] ir);
      return ir[8:6];
   endfunction

   function automatic logic [2:0] f_rb(input logic [IW-1:0] ir);
      return ir[5:3];
   endfunction

   function automatic logic [DW-1:0] f_imm(input logic [IW-1:0] ir);
      return ir[7:0];
   endfunction

endpackage

// File: rtl/simple_cpu_alu.sv
// Combinational ALU: result, zero flag and carry/borrow/shifted-out bit.
module simple_cpu_alu
   import simple_cpu_pkg::*;
(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [3:0]    op,
   output logic [DW-1:0] y,
   output logic          z,
   output logic          c
);

   logic [DW:0] sum;

   always_comb begin
      sum = '0;
      y   = '0;
      c   = 1'b0;
      case (op)
         OP_ADD, OP_ADDI: begin
            sum = {1'b0, a} + {1'b0, b};
            y   = sum[DW-1:0];
            c   = sum[DW];
         end
         OP_SUB: begin
            // wrap of the 9-bit difference doubles as the borrow
            sum = {1'b0, a} - {1'b0, b};
            y   = sum[DW-1:0];
            c   = sum[DW];
         end
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_SHL: begin
            y = {a[DW-2:0], 1'b0};
            c = a[DW-1];
         end
         OP_SHR: begin
            y = {1'b0, a[DW-1:1]};
            c = a[0];
         end
         default: ;
      endcase
   end

   assign z = (y == '0);

endmodule

// File: rtl/simple_cpu_top.sv
// Multicycle 8-bit register CPU: fetch over im_* bus, LD/ST over dm_* bus.
module simple_cpu_top
   import simple_cpu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   output logic          im_abus_valid,
   output logic [AW-1:0] im_abus_data,
   input  logic [IW-1:0] im_dbus,
   output logic          rd_mem,
   output logic          wr_mem,
   output logic [AW-1:0] dm_abus,
   input  logic [DW-1:0] dm_in_dbus,
   output logic [DW-1:0] dm_out_dbus
);

   state_t        state, state_n;
   logic [AW-1:0] pc, pc_n;
   logic [IW-1:0] ir, ir_n;
   logic [DW-1:0] regs [NREG];
   logic          z, c, z_n, c_n;
   logic          we;
   logic [2:0]    wa;
   logic [DW-1:0] wd;
   logic [DW-1:0] alu_a, alu_b, alu_y;
   logic          alu_z, alu_c;
   logic [3:0]    op;
   logic          mem_phase;

   assign op = f_op(ir);

   simple_cpu_alu u_alu (
      .a  (alu_a),
      .b  (alu_b),
      .op (op),
      .y  (alu_y),
      .z  (alu_z),
      .c  (alu_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_F1;
         pc    <= '0;
         ir    <= '0;
         z     <= 1'b0;
         c     <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         ir    <= ir_n;
         z     <= z_n;
         c     <= c_n;
         if (we) regs[wa] <= wd;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      ir_n    = ir;
      z_n     = z;
      c_n     = c;
      we      = 1'b0;
      wa      = f_rd(ir);
      wd      = alu_y;
      alu_a   = regs[f_ra(ir)];
      alu_b   = regs[f_rb(ir)];
      if (op == OP_ADDI) begin
         alu_a = regs[f_rd(ir)];
         alu_b = f_imm(ir);
      end
      case (state)
         S_F1: state_n = S_F2;
         S_F2: begin
            ir_n    = im_dbus;
            state_n = S_EX;
         end
         S_EX: begin
            state_n = S_F1;
            pc_n    = pc + AW'(1);
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADDI: begin
                  we  = 1'b1;
                  z_n = alu_z;
                  c_n = alu_c;
               end
               OP_LDI: begin
                  we = 1'b1;
                  wd = f_imm(ir);
               end
               OP_LD, OP_ST: state_n = S_M1;
               OP_JMP:       pc_n = f_imm(ir);
               OP_BZ:        if (z)  pc_n = f_imm(ir);
               OP_BNZ:       if (!z) pc_n = f_imm(ir);
               OP_HALT: begin
                  state_n = S_HALT;
                  pc_n    = pc;
               end
               OP_NOP:  ;
               default: ;
            endcase
         end
         S_M1: state_n = (op == OP_LD) ? S_M2 : S_F1;
         S_M2: begin
            we      = 1'b1;
            wd      = dm_in_dbus;
            state_n = S_F1;
         end
         S_HALT: ;
         default: state_n = S_F1;
      endcase
   end

   // Bus strobes decode the state register; valid is masked while reset is held
   assign mem_phase     = (state == S_M1) || (state == S_M2);
   assign im_abus_valid = !reset && ((state == S_F1) || (state == S_F2));
   assign im_abus_data  = pc;
   assign rd_mem        = mem_phase && (op == OP_LD);
   assign wr_mem        = (state == S_M1) && (op == OP_ST);
   assign dm_abus       = mem_phase ? f_imm(ir) : '0;
   assign dm_out_dbus   = wr_mem ? regs[f_rd(ir)] : '0;

endmodule

// File: tb/tb_simple_cpu_top.sv
// Bench for simple_cpu_top: instruction-level reference model vs. observed bus traffic.
module tb_simple_cpu_top;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        im_abus_valid;
   logic [7:0]  im_abus_data;
   logic [15:0] im_dbus;
   logic        rd_mem, wr_mem;
   logic [7:0]  dm_abus;
   logic [7:0]  dm_in_dbus;
   logic [7:0]  dm_out_dbus;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [1:0] len;
   } tx_t;

   int   checks = 0;
   int   errors = 0;
   int   viol   = 0;
   int   mcyc   = 0;
   int   obs_fa[$], obs_fc[$];
   int   exp_fa[$], exp_cpi[$];
   tx_t  obs_tx[$], exp_tx[$];
   logic [15:0] imem [256];
   logic [7:0]  dmem [256];
   logic [7:0]  mdm  [256];

   simple_cpu_top dut (
      .clk           (clk),
      .reset         (reset),
      .im_abus_valid (im_abus_valid),
      .im_abus_data  (im_abus_data),
      .im_dbus       (im_dbus),
      .rd_mem        (rd_mem),
      .wr_mem        (wr_mem),
      .dm_abus       (dm_abus),
      .dm_in_dbus    (dm_in_dbus),
      .dm_out_dbus   (dm_out_dbus)
   );

   always #5 clk = ~clk;

   // synchronous-read memories, one cycle latency
   always @(posedge clk) begin
      im_dbus    <= imem[im_abus_data];
      dm_in_dbus <= dmem[dm_abus];
      if (wr_mem) dmem[dm_abus] <= dm_out_dbus;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ei(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
      return {op, rd, 1'b0, imm};
   endfunction

   function automatic logic [15:0] er(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb);
      return {op, rd, ra, rb, 3'b000};
   endfunction

   // bus monitor: fetch starts, memory transactions, protocol violations
   initial begin : monitor
      bit  pv;
      int  run;
      tx_t cur;
      pv  = 1'b0;
      run = 0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pv   = 1'b0;
            run  = 0;
            mcyc = 0;
         end else begin
            mcyc++;
            if (im_abus_valid && !pv) begin
               obs_fa.push_back(int'(im_abus_data));
               obs_fc.push_back(mcyc);
            end
            pv = im_abus_valid;
            if (rd_mem && wr_mem) viol++;
            if (!rd_mem && !wr_mem && (dm_abus != 8'h00 || dm_out_dbus != 8'h00)) viol++;
            if (rd_mem || wr_mem) begin
               if (run == 0) begin
                  cur.wr   = wr_mem;
                  cur.addr = dm_abus;
                  cur.data = dm_out_dbus;
               end else if (cur.addr != dm_abus || cur.wr != wr_mem) begin
                  viol++;
               end
               run++;
            end else if (run > 0) begin
               cur.len = 2'(run);
               obs_tx.push_back(cur);
               run = 0;
            end
         end
      end
   end

   // Instruction-at-a-time model from the ISA rules
   task automatic model_run(output int cycles);
      logic [7:0] r [8];
      logic [7:0] pc, pc_next, imm;
      logic [15:0] w;
      logic [3:0] op;
      logic zf, cf;
      int a, b, s, cpi, steps;
      bit halted;
      tx_t t;
      for (int i = 0; i < 8; i++) r[i] = 8'h00;
      for (int i = 0; i < 256; i++) mdm[i] = dmem[i];
      exp_fa.delete(); exp_cpi.delete(); exp_tx.delete();
      pc = 8'h00; zf = 1'b0; cf = 1'b0;
      cycles = 0; steps = 0; halted = 1'b0;
      while (!halted && steps < 400) begin
         w = imem[pc]; op = w[15:12]; imm = w[7:0];
         exp_fa.push_back(int'(pc));
         pc_next = pc + 8'd1;
         cpi = 3;
         case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE: begin
               a = int'(r[w[8:6]]);
               b = int'(r[w[5:3]]);
               if (op == 4'hE) begin a = int'(r[w[11:9]]); b = int'(imm); end
               s = 0;
               case (op)
                  4'h1, 4'hE: begin s = a + b; cf = (s > 255); end
                  4'h2: begin s = a - b; cf = (s < 0); end
                  4'h3: begin s = a & b; cf = 1'b0; end
                  4'h4: begin s = a | b; cf = 1'b0; end
                  4'h5: begin s = a ^ b; cf = 1'b0; end
                  4'h6: begin s = a * 2; cf = (a >= 128); end
                  default: begin s = a / 2; cf = (a % 2 == 1); end
               endcase
               s = (s + 256) % 256;
               r[w[11:9]] = 8'(s);
               zf = (s == 0);
            end
            4'h8: r[w[11:9]] = imm;
            4'h9: begin
               r[w[11:9]] = mdm[imm];
               t = '{wr: 1'b0, addr: imm, data: 8'h00, len: 2'd2};
               exp_tx.push_back(t);
               cpi = 5;
            end
            4'hA: begin
               mdm[imm] = r[w[11:9]];
               t = '{wr: 1'b1, addr: imm, data: r[w[11:9]], len: 2'd1};
               exp_tx.push_back(t);
               cpi = 4;
            end
            4'hB: pc_next = imm;
            4'hC: if (zf) pc_next = imm;
            4'hD: if (!zf) pc_next = imm;
            4'hF: halted = 1'b1;
            default: ;
         endcase
         exp_cpi.push_back(cpi);
         cycles += cpi;
         pc = pc_next;
         steps++;
      end
      chk("model_halts", 32'(halted), 32'd1);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         imem[i] = 16'hF000;
         dmem[i] <= 8'h00;
      end
   endtask

   task automatic run_prog(input string name);
      int total;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_run(total);
      obs_fa.delete(); obs_fc.delete(); obs_tx.delete();
      viol = 0;
      reset = 1'b0;
      repeat (total + 20) @(posedge clk);
      #1;
      chk({name, ".nfetch"}, 32'(obs_fa.size()), 32'(exp_fa.size()));
      if (obs_fa.size() > 0) chk({name, ".fc0"}, 32'(obs_fc[0]), 32'd1);
      for (int k = 0; k < obs_fa.size() && k < exp_fa.size(); k++) begin
         chk($sformatf("%s.fa%0d", name, k), 32'(obs_fa[k]), 32'(exp_fa[k]));
         if (k > 0)
            chk($sformatf("%s.cpi%0d", name, k - 1), 32'(obs_fc[k] - obs_fc[k-1]), 32'(exp_cpi[k-1]));
      end
      chk({name, ".ntx"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
      for (int k = 0; k < obs_tx.size() && k < exp_tx.size(); k++)
         chk($sformatf("%s.tx%0d", name, k), 32'(obs_tx[k]), 32'(exp_tx[k]));
      chk({name, ".viol"}, 32'(viol), 32'd0);
      chk({name, ".halted"}, 32'(im_abus_valid), 32'd0);
      for (int i = 0; i < 256; i++)
         chk($sformatf("%s.dm%02h", name, i), 32'(dmem[i]), 32'(mdm[i]));
   endtask

   initial begin : stim
      logic [15:0] w;
      logic [3:0]  op;
      int          tgt, fa2;
      bit          seen;

      clear_mem();
      reset = 1'b1;
      #100;
      chk("rst.valid", 32'(im_abus_valid), 32'd0);
      chk("rst.rd", 32'(rd_mem), 32'd0);
      chk("rst.wr", 32'(wr_mem), 32'd0);
      chk("rst.dmab", 32'(dm_abus), 32'd0);

      // LDI/LDI/ADD/ST
      imem[0] = ei(4'h8, 3'd1, 8'h05);
      imem[1] = ei(4'h8, 3'd2, 8'h03);
      imem[2] = er(4'h1, 3'd3, 3'd1, 3'd2);
      imem[3] = ei(4'hA, 3'd3, 8'h10);
      run_prog("add_st");
      chk("add_st.first", 32'(obs_fa.size() > 0 ? obs_fa[0] : -1), 32'h0);
      chk("add_st.mem10", 32'(dmem[8'h10]), 32'h08);
      if (obs_tx.size() > 0) begin
         chk("add_st.wrlen", 32'(obs_tx[0].len), 32'd1);
         chk("add_st.wraddr", 32'(obs_tx[0].addr), 32'h10);
      end

      // LD then ST of the loaded register
      clear_mem();
      dmem[8'h20] <= 8'hAA;
      imem[0] = ei(4'h9, 3'd4, 8'h20);
      imem[1] = ei(4'hA, 3'd4, 8'h21);
      run_prog("ld_st");
      chk("ld_st.mem21", 32'(dmem[8'h21]), 32'hAA);
      if (obs_tx.size() > 0) chk("ld_st.rdlen", 32'(obs_tx[0].len), 32'd2);

      // ADDI wrap sets Z and C; BZ taken
      clear_mem();
      dmem[8'h41] <= 8'h5A;
      imem[0]     = ei(4'h8, 3'd1, 8'hFF);
      imem[1]     = ei(4'hE, 3'd1, 8'h01);
      imem[2]     = ei(4'hC, 3'd0, 8'h40);
      imem[8'h40] = ei(4'hA, 3'd1, 8'h41);
      run_prog("addi_bz");
      chk("addi_bz.fa3", 32'(obs_fa.size() > 3 ? obs_fa[3] : -1), 32'h40);
      chk("addi_bz.mem41", 32'(dmem[8'h41]), 32'h00);

      // countdown loop
      clear_mem();
      dmem[8'h50] <= 8'h5A;
      imem[0] = ei(4'h8, 3'd1, 8'h03);
      imem[1] = ei(4'h8, 3'd2, 8'h01);
      imem[2] = er(4'h2, 3'd1, 3'd1, 3'd2);
      imem[3] = ei(4'hD, 3'd0, 8'h02);
      imem[4] = ei(4'hA, 3'd1, 8'h50);
      run_prog("loop");
      fa2 = 0;
      foreach (obs_fa[k]) if (obs_fa[k] == 2) fa2++;
      chk("loop.iters", 32'(fa2), 32'd3);
      chk("loop.mem50", 32'(dmem[8'h50]), 32'h00);

      // JMP 0xFF, NOP at 0xFF wraps PC to 0x00
      clear_mem();
      dmem[8'h30] <= 8'h5A;
      imem[0]     = ei(4'hE, 3'd7, 8'h80);
      imem[1]     = ei(4'hC, 3'd0, 8'h03);
      imem[2]     = ei(4'hB, 3'd0, 8'hFF);
      imem[3]     = ei(4'hA, 3'd7, 8'h30);
      imem[8'hFF] = 16'h0000;
      run_prog("wrap");
      chk("wrap.fa4", 32'(obs_fa.size() > 4 ? obs_fa[4] : -1), 32'h00);
      chk("wrap.nfetch8", 32'(obs_fa.size()), 32'd8);

      // reset during the ST write cycle must suppress the write
      clear_mem();
      imem[0] = ei(4'h8, 3'd1, 8'h77);
      imem[1] = ei(4'hA, 3'd1, 8'h60);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (wr_mem) seen = 1'b1;
      end
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst.seen", 32'(seen), 32'd1);
      chk("midrst.wr", 32'(wr_mem), 32'd0);
      chk("midrst.mem60", 32'(dmem[8'h60]), 32'h00);
      // registers must also be cleared: ST r1 without reloading it
      dmem[8'h60] <= 8'h5A;
      imem[0] = 16'h0000;
      run_prog("midrst2");
      chk("midrst2.mem60", 32'(dmem[8'h60]), 32'h00);

      // random forward-only programs, registers dumped to 0xF0..0xF7 at the end
      for (int t = 0; t < 6; t++) begin
         clear_mem();
         for (int i = 0; i < 256; i++) dmem[i] <= 8'($urandom());
         for (int pc = 0; pc < 40; pc++) begin
            w  = 16'($urandom());
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 9) != 0) op = 4'($urandom_range(0, 14));
            w[15:12] = op;
            if (op == 4'hB || op == 4'hC || op == 4'hD) begin
               tgt     = int'($urandom_range(pc + 1, 48));
               w[7:0]  = 8'(tgt);
            end
            imem[pc] = w;
         end
         for (int i = 0; i < 8; i++) imem[40 + i] = ei(4'hA, 3'(i), 8'(8'hF0 + i));
         run_prog($sformatf("rnd%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
